// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: operand width default, divider FSM encoding, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_pkg;

    // Default operand width, matching the 16x16 multiplier that feeds the divider.
    localparam int BIT_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } div_state_t;

    // Iteration counter width: enough to count 2*bit_w iterations with headroom.
    function automatic int cnt_width(input int bit_w);
        return $clog2(2 * bit_w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
    parameter int BIT = 16
) (
    input  logic [BIT:0]   rem_in,
    input  logic           bit_in,
    input  logic [BIT-1:0] divisor,
    output logic [BIT:0]   rem_out,
    output logic           q_bit
);

    logic [BIT+1:0] shifted;
    logic [BIT+1:0] trial;

    // One extra bit above the partial remainder keeps the trial sign exact for any operand.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[BIT+1];
        rem_out = q_bit ? trial[BIT:0] : shifted[BIT:0];
    end

endmodule

// File: rtl/seq_divider_32x16.sv
// Sequential unsigned radix-2 restoring divider, 2*BIT-bit dividend by BIT-bit divisor.
// Latency: 2*BIT cycles after acceptance (1 cycle for a zero divisor); one op in flight.
// Backpressure: in_ready low while busy; result held stable until out_valid && out_ready.
module seq_divider_32x16
    import arith_pkg::*;
#(
    parameter int BIT = BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*BIT-1:0] dividend,
    input  logic [BIT-1:0]   divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*BIT-1:0] quotient,
    output logic [BIT-1:0]   remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(BIT);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * BIT - 1);

    div_state_t       state;
    logic [BIT:0]     rem_q;
    logic [2*BIT-1:0] quot_q;
    logic [BIT-1:0]   dvsr_q;
    logic [CNT_W-1:0] cnt;

    logic [BIT:0]     rem_nxt;
    logic             q_bit;

    // The shift register's MSB is the next dividend bit; its LSB end collects quotient bits.
    div_step #(.BIT(BIT)) u_step (
        .rem_in  (rem_q),
        .bit_in  (quot_q[2*BIT-1]),
        .divisor (dvsr_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quotient  = quot_q;
    assign remainder = rem_q[BIT-1:0];

    // Control FSM and datapath registers; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        dvsr_q   <= divisor;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to a flagged result.
                            quot_q      <= '1;
                            rem_q       <= {1'b0, dividend[BIT-1:0]};
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            quot_q      <= dividend;
                            rem_q       <= '0;
                            div_by_zero <= 1'b0;
                            state       <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= {quot_q[2*BIT-2:0], q_bit};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result stays frozen until the consumer takes it; no accept in the same cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32x16.sv
// Directed and randomised checks of the sequential divider against hand values and the / and % operators.
// Latency: checks 2*BIT-cycle result timing and 1-cycle zero-divisor timing.
// Backpressure: holds out_ready low to confirm the result stays frozen.
module tb_seq_divider_32x16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider_32x16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge with the DUT idle. lat = rising edges after the accepting edge
    // until out_valid is seen. With out_ready high the result is consumed before returning.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                          output logic [31:0] q, output logic [15:0] r,
                          output logic dz, output int lat);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("timeout", 64'(out_valid), 64'd1);
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
        int          rises;
        logic [15:0] a, b;
        logic [31:0] dd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1000 / 7 = 142 r 6, result 32 edges after acceptance
        run_op(32'd1000, 16'd7, q, r, dz, lat);
        chk("lat_1000_7", 64'(lat), 64'd32);
        chk("q_1000_7", 64'(q), 64'd142);
        chk("r_1000_7", 64'(r), 64'd6);
        chk("dbz_1000_7", 64'(dz), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // All-ones dividend by all-ones divisor
        run_op(32'hFFFF_FFFF, 16'hFFFF, q, r, dz, lat);
        chk("q_max", 64'(q), 64'h0001_0001);
        chk("r_max", 64'(r), 64'd0);

        // Dividend smaller than divisor
        run_op(32'h0000_0003, 16'h0010, q, r, dz, lat);
        chk("q_small", 64'(q), 64'd0);
        chk("r_small", 64'(r), 64'd3);

        // Divide by zero: result in the cycle right after acceptance
        run_op(32'd5, 16'd0, q, r, dz, lat);
        chk("lat_div0", 64'(lat), 64'd0);
        chk("q_div0", 64'(q), 64'hFFFF_FFFF);
        chk("r_div0", 64'(r), 64'd5);
        chk("dbz_div0", 64'(dz), 64'd1);

        // Zero dividend still takes the full iteration count
        run_op(32'd0, 16'd123, q, r, dz, lat);
        chk("lat_zero", 64'(lat), 64'd32);
        chk("q_zero", 64'(q), 64'd0);
        chk("r_zero", 64'(r), 64'd0);
        chk("dbz_cleared", 64'(dz), 64'd0);

        // Divisor of one passes the dividend through
        run_op(32'hDEAD_BEEF, 16'd1, q, r, dz, lat);
        chk("q_div1", 64'(q), 64'hDEAD_BEEF);
        chk("r_div1", 64'(r), 64'd0);

        // Backpressure: 100 / 9 = 11 r 1 held while out_ready is low
        out_ready = 1'b0;
        run_op(32'd100, 16'd9, q, r, dz, lat);
        chk("bp_q_first", 64'(q), 64'd11);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_quotient", 64'(quotient), 64'd11);
            chk("bp_remainder", 64'(remainder), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of an operation
        dividend = 32'd1000;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        chk("abort_no_result", 64'(rises), 64'd0);
        run_op(32'd42, 16'd6, q, r, dz, lat);
        chk("q_42_6", 64'(q), 64'd7);
        chk("r_42_6", 64'(r), 64'd0);

        // Round trip: product of two 16-bit values divided by one factor
        for (int i = 0; i < 150; i++) begin
            a  = 16'($urandom_range(0, 65535));
            b  = 16'($urandom_range(1, 65535));
            dd = {16'd0, a} * {16'd0, b};
            run_op(dd, b, q, r, dz, lat);
            chk("rt_quotient", 64'(q), 64'(a));
            chk("rt_remainder", 64'(r), 64'd0);
        end

        // Random pairs against the reference operators and the division identity
        for (int i = 0; i < 150; i++) begin
            dd = $urandom;
            b  = 16'($urandom_range(1, 65535));
            run_op(dd, b, q, r, dz, lat);
            chk("rnd_quotient", 64'(q), 64'(dd / {16'd0, b}));
            chk("rnd_remainder", 64'(r), 64'(dd % {16'd0, b}));
            chk("rnd_identity", 64'(q) * 64'(b) + 64'(r), 64'(dd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
